ram_access_ctrl: RTL

Initiator-side controller for the 16 x 8-bit data RAM. It accepts single load/store requests from the datapath over a valid/ready handshake and sequences them onto the RAM strobes MemWrite/MemRead/Address/WriteData. It captures MemData_in and returns one response per request over a second valid/ready handshake. It sits between the core's memory stage and the data RAM and is the only driver of the RAM control inputs.

---
 rtl/ram_access_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Initiator-side controller for a 16 x 8-bit data RAM. The controller takes
//   one load or store at a time over a valid/ready request handshake. It drives
//   the RAM strobes for that access and returns one response per request over
//   a second valid/ready handshake.
//
// Optional feature, selected by the macro WRITE_VERIFY_EN:
//   When the macro is defined, every store reads the location back in a VERIFY
//   cycle, and rsp_err flags a read-back mismatch.
//   When it is undefined, stores go WRITE -> RESP and rsp_err is tied to 0.
//
// Ports
//   clk, reset         system clock; asynchronous active-high reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_write          1 = store, 0 = load
//   req_addr/wdata     word address / store data
//   rsp_valid/ready    response handshake
//   rsp_rdata          load data (8'h00 for stores)
//   rsp_err            write-verify mismatch
//   MemWrite/MemRead   RAM strobes, decoded from state only
//   Address/WriteData  RAM address / write data, zero outside an access
//   MemData_in         combinational RAM read data
module ram_access_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       MemWrite,
  output logic       MemRead,
  output logic [3:0] Address,
  output logic [7:0] WriteData,
  input  logic [7:0] MemData_in
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    VERIFY = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] addr_q,  addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic [7:0] rdata_q, rdata_d;
`ifdef WRITE_VERIFY_EN
  logic       err_q,   err_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 4'h0;
      wdata_q <= 8'h00;
      write_q <= 1'b0;
      rdata_q <= 8'h00;
`ifdef WRITE_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
`ifdef WRITE_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
`ifdef WRITE_VERIFY_EN
    err_d     = err_q;
`endif
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 8'h00;
    rsp_err   = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    Address   = 4'h0;
    WriteData = 8'h00;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          state_d = req_write ? WRITE : READ;
`ifdef WRITE_VERIFY_EN
          // A stale error must not leak into the next response.
          err_d   = 1'b0;
`endif
        end
      end
      WRITE: begin
        MemWrite  = 1'b1;
        Address   = addr_q;
        WriteData = wdata_q;
        rdata_d   = 8'h00;
`ifdef WRITE_VERIFY_EN
        state_d   = VERIFY;
`else
        state_d   = RESP;
`endif
      end
      READ: begin
        MemRead = 1'b1;
        Address = addr_q;
        rdata_d = MemData_in;
        state_d = RESP;
      end
`ifdef WRITE_VERIFY_EN
      VERIFY: begin
        MemRead = 1'b1;
        Address = addr_q;
        err_d   = (MemData_in != wdata_q);
        state_d = RESP;
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        // Stores always report zero data, independent of rdata_q history.
        rsp_rdata = write_q ? 8'h00 : rdata_q;
`ifdef WRITE_VERIFY_EN
        rsp_err   = err_q;
`endif
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
